// File: rtl/pix_window_collector.sv
// Regroups a PE pixel-memory stream into tagged 3-pixel windows and tracks frame pass count.
// Optional overlap check between consecutive windows: define PIX_OVERLAP_CHECK_EN.
module pix_window_collector #(
  parameter int DWIDTH = 8,
  parameter int PE_NUM = 0,
  parameter int PASS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pix_in_valid,
  output logic                  pix_in_ready,
  input  logic [DWIDTH-1:0]     pix_in_data,
  output logic                  win_out_valid,
  input  logic                  win_out_ready,
  output logic [3*DWIDTH-1:0]   win_out_data,
  output logic [1:0]            win_out_pos,
  output logic [PASS_W-1:0]     win_out_pass,
  output logic                  win_out_last,
  output logic                  frame_done,
  output logic                  overlap_err
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [PASS_W-1:0] FIRST_LAST_PASS = PASS_W'(PE_NUM);
  localparam logic [PASS_W-1:0] LATER_LAST_PASS = PASS_W'(2);

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  valid_q, valid_d;
  logic [2*DWIDTH-1:0]   sh_q, sh_d;
  logic [1:0]            pix_cnt_q, pix_cnt_d;
  logic [1:0]            pos_cnt_q, pos_cnt_d;
  logic [PASS_W-1:0]     pass_cnt_q, pass_cnt_d;
  logic                  first_frame_q, first_frame_d;
  logic [3*DWIDTH-1:0]   data_q, data_d;
  logic [1:0]            wpos_q, wpos_d;
  logic [PASS_W-1:0]     wpass_q, wpass_d;
  logic                  wlast_q, wlast_d;
  logic                  done_q, done_d;

  logic pix_xfer_s;
  logic win_acc_s;
  logic last_s;
  logic hold_entry_s;

  assign pix_xfer_s   = pix_in_valid && ready_q;
  assign win_acc_s    = valid_q && win_out_ready;
  assign last_s       = (pos_cnt_q == 2'd2) &&
                        (pass_cnt_q == (first_frame_q ? FIRST_LAST_PASS : LATER_LAST_PASS));
  assign hold_entry_s = (state_q == COLLECT) && pix_xfer_s && (pix_cnt_q == 2'd2);

  // Next-state and registered-output logic for the collect/hold handshake.
  always_comb begin
    state_d       = state_q;
    ready_d       = ready_q;
    valid_d       = valid_q;
    sh_d          = sh_q;
    pix_cnt_d     = pix_cnt_q;
    pos_cnt_d     = pos_cnt_q;
    pass_cnt_d    = pass_cnt_q;
    first_frame_d = first_frame_q;
    data_d        = data_q;
    wpos_d        = wpos_q;
    wpass_d       = wpass_q;
    wlast_d       = wlast_q;
    done_d        = 1'b0;
    case (state_q)
      COLLECT: begin
        ready_d = 1'b1;
        valid_d = 1'b0;
        if (pix_xfer_s) begin
          sh_d = {sh_q[DWIDTH-1:0], pix_in_data};
          if (pix_cnt_q == 2'd2) begin
            pix_cnt_d = 2'd0;
            state_d   = HOLD;
            ready_d   = 1'b0;
            valid_d   = 1'b1;
            data_d    = {sh_q, pix_in_data};
            wpos_d    = pos_cnt_q;
            wpass_d   = pass_cnt_q;
            wlast_d   = last_s;
          end else begin
            pix_cnt_d = pix_cnt_q + 2'd1;
          end
        end else begin
          pix_cnt_d = pix_cnt_q;
        end
      end
      HOLD: begin
        if (win_acc_s) begin
          state_d = COLLECT;
          ready_d = 1'b1;
          valid_d = 1'b0;
          // Counters are unchanged during HOLD, so the registered last flag is current.
          if (wlast_q) begin
            pos_cnt_d     = 2'd0;
            pass_cnt_d    = '0;
            first_frame_d = 1'b0;
            done_d        = 1'b1;
          end else if (pos_cnt_q == 2'd2) begin
            pos_cnt_d  = 2'd0;
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
          end else begin
            pos_cnt_d = pos_cnt_q + 2'd1;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = COLLECT;
        ready_d = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      ready_q       <= 1'b0;
      valid_q       <= 1'b0;
      sh_q          <= '0;
      pix_cnt_q     <= 2'd0;
      pos_cnt_q     <= 2'd0;
      pass_cnt_q    <= '0;
      first_frame_q <= 1'b1;
      data_q        <= '0;
      wpos_q        <= 2'd0;
      wpass_q       <= '0;
      wlast_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      valid_q       <= valid_d;
      sh_q          <= sh_d;
      pix_cnt_q     <= pix_cnt_d;
      pos_cnt_q     <= pos_cnt_d;
      pass_cnt_q    <= pass_cnt_d;
      first_frame_q <= first_frame_d;
      data_q        <= data_d;
      wpos_q        <= wpos_d;
      wpass_q       <= wpass_d;
      wlast_q       <= wlast_d;
      done_q        <= done_d;
    end
  end

`ifdef PIX_OVERLAP_CHECK_EN
  logic err_q;
  logic mismatch_s;

  // data_q still holds the previous window while the next one is being collected.
  assign mismatch_s = (pos_cnt_q != 2'd0) && (sh_q != data_q[2*DWIDTH-1:0]);

  // Sticky overlap error, evaluated as a window enters HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (hold_entry_s && mismatch_s) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end

  assign overlap_err = err_q;
`else
  logic unused_s;
  assign unused_s    = hold_entry_s;
  assign overlap_err = 1'b0;
`endif

  assign pix_in_ready  = ready_q;
  assign win_out_valid = valid_q;
  assign win_out_data  = data_q;
  assign win_out_pos   = wpos_q;
  assign win_out_pass  = wpass_q;
  assign win_out_last  = wlast_q;
  assign frame_done    = done_q;

endmodule

// File: doc/pix_window_collector.md
# pix_window_collector

Clocked receive-side endpoint for a PE's single-pixel stream. It accepts the pixel sequence a PE pixel memory emits (per pass: p4,p3,p2, p3,p2,p1, p2,p1,p0), regroups it into 3-pixel convolution windows, and tags each window with its position and pass number. It tracks the frame-level pass count: the first frame after reset has PE_NUM+1 passes, and every later frame has 3. It sits between the pixel memory and the PE's multiply-accumulate datapath.

## Interface
- DWIDTH, 8, pixel width in bits
- PE_NUM, 0, PE index; sets the first-frame pass count to PE_NUM+1
- PASS_W, 4, pass counter width; must satisfy 2^PASS_W > max(PE_NUM, 2)

- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- pix_in_valid  in  1  an input pixel is present
- pix_in_ready  out  1  collector can accept a pixel
- pix_in_data  in  DWIDTH  single pixel
- win_out_valid  out  1  assembled window is present
- win_out_ready  in  1  downstream accepts the window
- win_out_data  out  3*DWIDTH  window; [3*DWIDTH-1:2*DWIDTH] holds the first pixel received, [DWIDTH-1:0] the third
- win_out_pos  out  2  window position within the pass, 0..2
- win_out_pass  out  PASS_W  pass index within the frame
- win_out_last  out  1  this window is the final window of the frame
- frame_done  out  1  one-cycle pulse after the last window is accepted
- overlap_err  out  1  sticky overlap-check error flag (see Configuration)

## Operation
- Two states.
  - COLLECT: pix_in_ready=1, win_out_valid=0.
  - HOLD: pix_in_ready=0, win_out_valid=1.
- A pixel transfer happens on an edge where pix_in_valid && pix_in_ready.
- In COLLECT, each transfer shifts the pixel into a 3-entry register and increments pix_cnt (0..2).
- On the third transfer, pix_cnt wraps to 0 and the state moves to HOLD.
- In HOLD, win_out_data, win_out_pos, win_out_pass and win_out_last are registered and stable until the window is accepted.
- A window is accepted on an edge where win_out_valid && win_out_ready. On acceptance:
  - The state returns to COLLECT.
  - pos_cnt advances 0→1→2→0. On the 2→0 wrap, pass_cnt increments.
- passes = first_frame ? PE_NUM+1 : 3.
- win_out_last = (pos_cnt==2) && (pass_cnt==passes-1).
- Accepting a window with win_out_last=1 does all of the following:
  - clears pos_cnt and pass_cnt;
  - clears first_frame (it is never set again until reset);
  - pulses frame_done for exactly one cycle, on the cycle after acceptance.
- pix_in_data is ignored while pix_in_ready=0. A held pix_in_valid is not consumed until COLLECT.
- Arithmetic: all counters are unsigned and wrap only as described above. No saturation is required.

## Timing
- Reset values (asserted asynchronously, held until the first edge after release):
  - state=COLLECT, pix_in_ready=0;
  - win_out_valid=0, win_out_data=0, win_out_pos=0, win_out_pass=0, win_out_last=0;
  - frame_done=0, overlap_err=0, first_frame=1;
  - all counters 0.
- pix_in_ready is registered. It rises on the first edge after rst_n deasserts.
- Latency: the third pixel accepted at edge N gives win_out_valid=1 after edge N.
- Throughput: with continuous valid/ready, a window takes 4 cycles (3 pixel cycles plus 1 hold cycle).
- When win_out_valid=1 and win_out_ready=1 on the same edge:
  - the window is accepted;
  - pix_in_ready=1 after that edge;
  - no pixel is accepted on that same edge.
- win_out_ready is ignored while win_out_valid=0.
- Reset mid-window or mid-frame discards the partial window and returns to first-frame counting. The next frame again expects PE_NUM+1 passes.

## Configuration
- PIX_OVERLAP_CHECK_EN defined:
  - On each window with pos 1 or 2, compare the new window's pixels 0 and 1 with the previous window's pixels 1 and 2.
  - The comparison is evaluated when the window enters HOLD.
  - Any mismatch sets overlap_err=1 on that edge. It stays set until reset.
  - Windows with pos 0 are not checked.
- PIX_OVERLAP_CHECK_EN undefined:
  - no comparison logic and no previous-window storage;
  - overlap_err is tied to 0.

## Test plan
- Reset release with PE_NUM=0, downstream always ready; feed pixels 5,4,3 → one window 0x050403, pos=0, pass=0, last=0, 4-cycle cadence.
- PE_NUM=0, feed one full pass 5,4,3,4,3,2,3,2,1 → three windows with pos 0,1,2. The third window has last=1, and frame_done pulses once. A second frame produces 3 passes (9 windows), with last=1 only on pass=2, pos=2.
- PE_NUM=2 first frame: 27 pixels give 9 windows, with last=1 only on pass=2, pos=2. The next frame also ends at pass=2.
- Backpressure: hold win_out_ready=0 for 5 cycles with pix_in_valid=1 → window data stable, pix_in_ready=0, no pixel lost. The next window is correct after release.
- Reset after 4 windows of the first frame (PE_NUM=1) → all outputs at reset values. The frame then restarts with 2 passes expected.
- PIX_OVERLAP_CHECK_EN: feed 5,4,3,4,9,2 → overlap_err=1 after the edge of the 6th pixel, and it stays 1 until rst_n=0. Without the macro, the same stimulus leaves overlap_err=0.
